qam_sym_packer: RTL
===================

// Module: qam_sym_packer
// PURPOSE
//   Packs a stream of DIN_W-bit chunks into symbols of runtime-selectable size (QPSK/QAM16/QAM64).
//   Each symbol is CHUNKS*DIN_W bits, where CHUNKS = mode+1.
//   Sits between the bit source and the QAM constellation mapper.
//   Adds to the fixed 2x2-bit input buffer:
//   - valid/ready back-pressure on both sides
//   - selectable modulation order
//   - explicit flush of a partial symbol
// PARAMETERS
//   DIN_W       2   width of one input chunk (bits)
//   MAX_CHUNKS  3   max chunks per symbol; OUT_W = DIN_W*MAX_CHUNKS
//   MODE_W      2   width of mode input; must be >= clog2(MAX_CHUNKS)
// PORTS
//   clk         in   1            single clock; all logic on posedge
//   rst         in   1            synchronous reset, active-high
//   mode        in   MODE_W       chunks per symbol minus 1 (0=QPSK,1=QAM16,2=QAM64); values >=MAX_CHUNKS clamp to MAX_CHUNKS-1
//   din         in   DIN_W        input chunk
//   din_valid   in   1            din holds a chunk
//   din_ready   out  1            chunk accepted when din_valid&&din_ready (fire_in)
//   flush       in   1            level request: emit the partial symbol, zero-padded
//   dout        out  OUT_W        symbol, right-aligned; bits above CHUNKS*DIN_W are 0
//   dout_valid  out  1            dout holds a symbol
//   dout_ready  in   1            symbol consumed when dout_valid&&dout_ready (fire_out)
// BEHAVIOUR
//   Reset: dout=0, dout_valid=0, acc=0, cnt=0, mode_q=0. din_ready follows the rule below (1 after reset).
//   Chunk order: first accepted chunk is the MSB chunk of the symbol; acc shifts left by DIN_W per chunk.
//   mode_q: captured from clamped mode on a fire_in with cnt==0. A mode change mid-symbol has no effect until the next symbol.
//   slot_free = !dout_valid || dout_ready.
//   din_ready = !flush && (slot_free || cnt+1 < CHUNKS(mode_q or mode if cnt==0)).
//     The accumulator keeps filling while the output stalls; only the completing chunk waits.
//   Completing chunk (fire_in, cnt+1==CHUNKS):
//     - dout <= {acc,din} zero-extended; dout_valid <= 1 next cycle (latency 1 clk from last chunk).
//     - cnt <= 0, acc <= 0.
//   Otherwise on fire_in: acc <= {acc,din}, cnt <= cnt+1.
//   fire_out without a new load: dout_valid <= 0; dout keeps its value.
//   fire_out and load in the same cycle: new symbol replaces the old one. dout_valid stays 1 with no bubble.
//   flush=1 blocks din (din_ready=0). Action depends on cnt:
//     - cnt>0 and slot_free: dout <= {acc,zeros} left-justified within CHUNKS*DIN_W; dout_valid <= 1; cnt <= 0.
//     - cnt>0 and !slot_free: waits while flush is held.
//     - cnt==0: no action; no empty symbol is emitted.
//   Boundaries:
//     - Never drops or duplicates a chunk under any valid/ready pattern.
//     - dout is stable while dout_valid && !dout_ready.
//     - cnt wraps only through the load path; cnt never reaches CHUNKS.
//     - rst mid-symbol discards acc and any pending dout; the next chunk starts a fresh symbol.
// STRUCTURE
//   Package qam_pkg:
//     - MODE_QPSK=0, MODE_QAM16=1, MODE_QAM64=2
//     - clog2 function
//     - chunks_of(mode) clamp function
//   Sub-module qam_out_stage: one-entry valid/ready output register.
//     - Inputs: load, ld_data, dout_ready. Outputs: dout, dout_valid, slot_free.
//   Top level holds acc, cnt, mode_q, flush logic and the din_ready equation.
// TESTING (DIN_W=2, MAX_CHUNKS=3)
//   1. mode=1, dout_ready=1, chunks 2'b10,2'b01 back-to-back -> dout=6'b00_1001, dout_valid for 1 clk, one clk after 2nd chunk.
//   2. mode=2, chunks 3,0,1 with dout_ready=0 until 4 clk later -> dout=6'b110001 held stable.
//      Next symbol's first two chunks accepted; its 3rd chunk stalls (din_ready=0) until fire_out.
//   3. mode=0, continuous din 0,1,2,3 with dout_ready=1 -> dout 0,1,2,3 on consecutive clks, dout_valid never drops.
//   4. mode=2, one chunk 2'b11 then flush=1 -> dout=6'b110000, cnt=0. flush with cnt==0 -> no dout_valid.
//   5. mode switched 1->2 after 1st chunk of a QAM16 symbol -> that symbol is 4-bit; the following symbol is 6-bit.
//   6. rst asserted after 2 chunks of a QAM64 symbol with dout_valid=1 -> next clk dout_valid=0, dout=0.
//      Then 3 chunks produce exactly one correct symbol.
//   Random valid/ready plus scoreboard: chunk-in vs symbol-out sequence matches, no loss or duplication.

Source files
------------

// File: rtl/qam_pkg.sv
// Shared constants and helpers for the QAM symbol packer: modulation codes,
// a constant-capable clog2 and the mode-to-chunk-count clamp.
package qam_pkg;

    localparam int MODE_QPSK  = 0;
    localparam int MODE_QAM16 = 1;
    localparam int MODE_QAM64 = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Out-of-range modes saturate to the largest supported symbol.
    function automatic int chunks_of(input int mode_val, input int max_chunks);
        if (mode_val >= max_chunks) begin
            return max_chunks;
        end
        return mode_val + 1;
    endfunction

endpackage

// File: rtl/qam_out_stage.sv
// One-entry valid/ready output register. A new symbol may replace the held one
// in the same cycle it is consumed, so back-to-back symbols see no bubble.
module qam_out_stage #(
    parameter int OUT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [OUT_W-1:0] ld_data,
    input  logic             dout_ready,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    output logic             slot_free
);

    logic [OUT_W-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;

    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        if (load) begin
            dout_d  = ld_data;
            valid_d = 1'b1;
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign slot_free  = !valid_q || dout_ready;

endmodule

// File: rtl/qam_sym_packer.sv
// Packs DIN_W-bit chunks MSB-first into QPSK/QAM16/QAM64 symbols with
// valid/ready on both sides and a flush that emits a zero-padded partial symbol.
module qam_sym_packer
    import qam_pkg::*;
#(
    parameter int DIN_W      = 2,
    parameter int MAX_CHUNKS = 3,
    parameter int MODE_W     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MODE_W-1:0]           mode,
    input  logic [DIN_W-1:0]            din,
    input  logic                        din_valid,
    output logic                        din_ready,
    input  logic                        flush,
    output logic [DIN_W*MAX_CHUNKS-1:0] dout,
    output logic                        dout_valid,
    input  logic                        dout_ready
);

    localparam int OUT_W = DIN_W * MAX_CHUNKS;
    localparam int CHK_W = (clog2(MAX_CHUNKS + 1) > 0) ? clog2(MAX_CHUNKS + 1) : 1;

    logic [OUT_W-1:0]  acc_q, acc_d;
    logic [CHK_W-1:0]  cnt_q, cnt_d;
    logic [MODE_W-1:0] mode_q, mode_d;

    logic [MODE_W-1:0] mode_clamped;
    logic [CHK_W-1:0]  chunks_in, chunks_held, chunks_cur, cnt_inc;
    logic [OUT_W-1:0]  acc_shift, flush_data, ld_data;
    logic              slot_free, fire_in, completing, flush_go, load;

    assign mode_clamped = MODE_W'(chunks_of(int'(mode), MAX_CHUNKS) - 1);
    assign chunks_in    = CHK_W'(chunks_of(int'(mode), MAX_CHUNKS));
    assign chunks_held  = CHK_W'(int'(mode_q) + 1);

    // The first chunk of a symbol decides its size, so the live mode applies only at cnt==0.
    assign chunks_cur = (cnt_q == '0) ? chunks_in : chunks_held;
    assign cnt_inc    = cnt_q + CHK_W'(1);

    // Only the completing chunk needs a free output slot; earlier chunks keep filling acc.
    assign din_ready  = !flush && (slot_free || (cnt_inc < chunks_cur));
    assign fire_in    = din_valid && din_ready;
    assign completing = fire_in && (cnt_inc == chunks_cur);
    assign flush_go   = flush && (cnt_q != '0) && slot_free;

    assign acc_shift  = (acc_q << DIN_W) | OUT_W'(din);
    assign flush_data = acc_q << (DIN_W * (int'(chunks_held) - int'(cnt_q)));

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        load    = 1'b0;
        ld_data = '0;
        if (fire_in) begin
            if (cnt_q == '0) begin
                mode_d = mode_clamped;
            end
            if (completing) begin
                load    = 1'b1;
                ld_data = acc_shift;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = acc_shift;
                cnt_d = cnt_inc;
            end
        end else if (flush_go) begin
            load    = 1'b1;
            ld_data = flush_data;
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            mode_q <= '0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    qam_out_stage #(
        .OUT_W(OUT_W)
    ) u_out_stage (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .ld_data   (ld_data),
        .dout_ready(dout_ready),
        .dout      (dout),
        .dout_valid(dout_valid),
        .slot_free (slot_free)
    );

endmodule
